// File: rtl/aes_key_expand_byte.sv
// Byte-serial AES-128 key expansion. Loads a 128-bit cipher key and streams round keys 0..10
// one byte per accepted cycle, deriving each next key with one shared S-box over a 5-cycle
// SUB/MIX window between rounds.

// Combinational AES forward S-box (table lookup).
module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);

  // Entry 0 occupies the most significant byte.
  localparam logic [2047:0] Table = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign y = Table[{~a, 3'b000} +: 8];

endmodule

// Round-key byte streamer with on-the-fly key schedule.
module aes_key_expand_byte (
  input  logic         clk,
  input  logic         rst,
  input  logic         kld,
  input  logic [127:0] key_in,
  input  logic         adv,
  output logic [7:0]   w_o,
  output logic         w_vld,
  output logic [3:0]   rnd_o,
  output logic         last_o,
  output logic         done
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StOut  = 2'd1;
  localparam logic [1:0] StSub  = 2'd2;
  localparam logic [1:0] StMix  = 2'd3;

  logic [1:0]   state;
  logic [127:0] k;      // byte i of the round key lives at k[127-8*i -: 8]
  logic [31:0]  t;      // SubWord(RotWord(w3)) scratch, t[0] in the top byte
  logic [3:0]   idx;
  logic [3:0]   rnd;
  logic [7:0]   rcon;
  logic [1:0]   sc;     // SUB sub-count

  logic [7:0]   sbox_in;
  logic [7:0]   sbox_out;
  logic [31:0]  w0, w1, w2, w3;
  logic [7:0]   rcon_next;

  // Feed the S-box with the last key word in RotWord order: k13, k14, k15, k12.
  always_comb begin
    sbox_in = 8'h00;
    case (sc)
      2'd0:    sbox_in = k[23:16];
      2'd1:    sbox_in = k[15:8];
      2'd2:    sbox_in = k[7:0];
      default: sbox_in = k[31:24];
    endcase
  end

  aes_sbox u_sbox (
    .a (sbox_in),
    .y (sbox_out)
  );

  // Next round key and round constant, consumed only in MIX.
  always_comb begin
    w0        = k[127:96] ^ {t[31:24] ^ rcon, t[23:0]};
    w1        = k[95:64] ^ w0;
    w2        = k[63:32] ^ w1;
    w3        = k[31:0] ^ w2;
    rcon_next = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
  end

  // Sequencer: key load has priority over every state; adv only matters in OUT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= StIdle;
      k     <= '0;
      t     <= '0;
      idx   <= '0;
      rnd   <= '0;
      rcon  <= 8'h01;
      sc    <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (kld) begin
        k     <= key_in;
        idx   <= '0;
        rnd   <= '0;
        rcon  <= 8'h01;
        sc    <= '0;
        state <= StOut;
      end else begin
        case (state)
          StOut: begin
            if (adv) begin
              if (idx != 4'd15) begin
                idx <= idx + 4'd1;
              end else if (rnd == 4'd10) begin
                idx   <= '0;
                done  <= 1'b1;
                state <= StIdle;
              end else begin
                idx   <= '0;
                sc    <= '0;
                state <= StSub;
              end
            end
          end
          StSub: begin
            t[{~sc, 3'b000} +: 8] <= sbox_out;
            sc                    <= sc + 2'd1;
            if (sc == 2'd3) state <= StMix;
          end
          StMix: begin
            k     <= {w0, w1, w2, w3};
            rnd   <= rnd + 4'd1;
            rcon  <= rcon_next;
            state <= StOut;
          end
          default: ;
        endcase
      end
    end
  end

  // Outputs decode from registers only.
  always_comb begin
    w_vld  = (state == StOut);
    w_o    = w_vld ? k[{~idx, 3'b000} +: 8] : 8'h00;
    rnd_o  = rnd;
    last_o = w_vld && (idx == 4'd15);
  end

endmodule

// File: tb/tb_aes_key_expand_byte.sv
// Directed bench for aes_key_expand_byte: FIPS-197 and all-zero key schedules, stalled stream,
// mid-round key reload and mid-round asynchronous reset.
module tb_aes_key_expand_byte;

  logic         clk = 1'b0;
  logic         rst;
  logic         kld;
  logic [127:0] key_in;
  logic         adv;
  logic [7:0]   w_o;
  logic         w_vld;
  logic [3:0]   rnd_o;
  logic         last_o;
  logic         done;

  aes_key_expand_byte dut (
    .clk    (clk),
    .rst    (rst),
    .kld    (kld),
    .key_in (key_in),
    .adv    (adv),
    .w_o    (w_o),
    .w_vld  (w_vld),
    .rnd_o  (rnd_o),
    .last_o (last_o),
    .done   (done)
  );

  always #5 clk = ~clk;

  localparam logic [127:0] KeyFips = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KeyZero = 128'h0;

  typedef struct {
    string        name;
    logic [127:0] key;
    int           round;
    logic [127:0] exp;
  } vec_t;

  vec_t       vecs [7];
  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] cap     [176];
  logic [7:0] ref_cap [176];
  int         nbytes, done_e, bubble_err, hold_err, tag_err;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Load a key and stream it to completion, recording bytes and protocol violations.
  task automatic run_seq(input logic [127:0] key, input bit rand_adv);
    logic [7:0] prev_w;
    bit         prev_hold;
    bit         a;
    int         acc15;
    kld = 1'b1; key_in = key; adv = 1'b0;
    @(negedge clk);
    kld = 1'b0;
    nbytes = 0; done_e = -1; acc15 = -1;
    bubble_err = 0; hold_err = 0; tag_err = 0; prev_hold = 1'b0; prev_w = 8'h00;
    for (int e = 0; e < 3000 && done_e < 0; e++) begin
      if (done) begin
        done_e = e;
        if (nbytes != 176 || w_vld) tag_err++;
      end
      if (w_vld) begin
        if (acc15 >= 0) begin
          if (e - acc15 != 6) bubble_err++;
          acc15 = -1;
        end
        if (prev_hold && w_o !== prev_w) hold_err++;
        if (rnd_o !== 4'(nbytes / 16) || last_o !== (nbytes % 16 == 15)) tag_err++;
      end else if (last_o) begin
        tag_err++;
      end
      a = rand_adv ? 1'($urandom_range(0, 1)) : 1'b1;
      adv = a;
      prev_hold = w_vld && !a;
      prev_w = w_o;
      if (w_vld && a && nbytes < 176) begin
        cap[nbytes] = w_o;
        if (nbytes % 16 == 15) acc15 = e;
        nbytes++;
      end
      @(negedge clk);
    end
    adv = 1'b0;
  endtask

  initial begin
    logic [127:0] got;
    int           diff;
    int           first_done;
    int           vld_err;

    rst = 1'b1; kld = 1'b0; adv = 1'b0; key_in = '0;
    repeat (2) @(negedge clk);
    check("reset_outputs", 128'({w_o, w_vld, rnd_o, last_o, done}), 128'h0);

    // adv held high with nothing loaded must not start anything
    rst = 1'b0; adv = 1'b1;
    repeat (5) @(negedge clk);
    check("idle_adv", 128'({w_o, w_vld, rnd_o, last_o, done}), 128'h0);
    adv = 1'b0;

    vecs[0] = '{"zero_r1",  KeyZero, 1,  128'h62636363626363636263636362636363};
    vecs[1] = '{"zero_r2",  KeyZero, 2,  128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa};
    vecs[2] = '{"zero_r10", KeyZero, 10, 128'hb4ef5bcb3e92e21123e951cf6f8f188e};
    vecs[3] = '{"fips_r0",  KeyFips, 0,  KeyFips};
    vecs[4] = '{"fips_r1",  KeyFips, 1,  128'ha0fafe1788542cb123a339392a6c7605};
    vecs[5] = '{"fips_r2",  KeyFips, 2,  128'hf2c295f27a96b9435935807a7359f67f};
    vecs[6] = '{"fips_r10", KeyFips, 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};

    for (int i = 0; i < 7; i++) begin
      if (i == 0 || vecs[i].key !== vecs[i-1].key) begin
        run_seq(vecs[i].key, 1'b0);
        check("done_cycle", 128'(done_e), 128'(226));
        check("byte_count", 128'(nbytes), 128'(176));
        check("bubble_len", 128'(bubble_err), 128'h0);
        check("tags_last", 128'(tag_err), 128'h0);
        check("done_width", 128'(done), 128'h0);
      end
      got = '0;
      for (int b = 0; b < 16; b++) got = {got[119:0], cap[vecs[i].round * 16 + b]};
      check(vecs[i].name, got, vecs[i].exp);
    end

    // Stalled stream must reproduce the continuous FIPS byte sequence
    for (int b = 0; b < 176; b++) ref_cap[b] = cap[b];
    run_seq(KeyFips, 1'b1);
    diff = 0;
    for (int b = 0; b < 176; b++) if (cap[b] !== ref_cap[b]) diff++;
    check("stall_bytes", 128'(diff), 128'h0);
    check("stall_count", 128'(nbytes), 128'(176));
    check("stall_hold", 128'(hold_err), 128'h0);
    check("stall_bubble", 128'(bubble_err), 128'h0);
    check("stall_tags", 128'(tag_err), 128'h0);
    check("stall_done_seen", 128'(done_e >= 226), 128'h1);

    // Reload during round 4 SUB: restart at byte 0, no done for the abandoned run
    kld = 1'b1; key_in = KeyFips;
    @(negedge clk);
    kld = 1'b0; adv = 1'b1;
    repeat (101) @(negedge clk);
    check("r4_in_sub", 128'({w_vld, rnd_o}), 128'({1'b0, 4'd4}));
    kld = 1'b1; key_in = 128'hf0e1d2c3b4a5968778695a4b3c2d1e0f;
    @(negedge clk);
    kld = 1'b0;
    check("abort_first_byte", 128'({w_vld, rnd_o, w_o}), 128'({1'b1, 4'd0, 8'hf0}));
    first_done = -1;
    for (int e = 0; e < 240 && first_done < 0; e++) begin
      if (done) first_done = e;
      @(negedge clk);
    end
    check("abort_done_cycle", 128'(first_done), 128'(226));
    adv = 1'b0;

    // Asynchronous reset during round 7 OUT at byte 9
    kld = 1'b1; key_in = KeyFips;
    @(negedge clk);
    kld = 1'b0; adv = 1'b1;
    repeat (156) @(negedge clk);
    check("r7_idx9", 128'({rnd_o, w_o, w_vld}), 128'({4'd7, 8'ha6, 1'b1}));
    #1 rst = 1'b1;
    #1;
    check("reset_midround", 128'({w_o, w_vld, rnd_o, last_o, done}), 128'h0);
    @(negedge clk);
    rst = 1'b0;
    vld_err = 0;
    for (int e = 0; e < 6; e++) begin
      @(negedge clk);
      if (w_vld || last_o || done || rnd_o != 4'd0) vld_err++;
    end
    check("post_reset_idle", 128'(vld_err), 128'h0);
    adv = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
